cpu_prefetch_buffer: RTL
========================

CPU_PREFETCH_BUFFER -- requirements
Module: cpu_prefetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port redirect  input  1  discard all prefetched/in-flight instructions; refetch from redirect_pc.
REQ-006 SHALL have port redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-007 SHALL have port deq  input  1  fetch stage consumes the head entry.
REQ-008 SHALL have port head_valid  output  1  head entry present.
REQ-009 SHALL have port head_instr  output  32  head instruction word.
REQ-010 SHALL have port head_pc  output  32  address of head instruction.
REQ-011 SHALL have port mem_req_valid  output  1  instruction-memory read request offered.
REQ-012 SHALL have port mem_req_addr  output  32  word address of offered request.
REQ-013 SHALL have port mem_req_ready  input  1  memory accepts the request this cycle.
REQ-014 SHALL have port mem_resp_valid  input  1  read data returned; responses in request order, latency >= 1 cycle.
REQ-015 SHALL have port mem_resp_data  input  32  returned instruction word.

Function
REQ-016 Request accepted SHALL mean mem_req_valid && mem_req_ready in the same cycle; each accept increments the fetch pointer by 4 (mod 2^32).
REQ-017 mem_req_valid SHALL be 1 iff queued + in-flight (including to-be-discarded) < DEPTH; counters DEPTH-width+1 bits, never overflow.
REQ-018 mem_req_addr SHALL equal the fetch pointer register; the request is a per-cycle offer and may change between cycles only on redirect.
REQ-019 A response with discard count 0 SHALL be enqueued with pc = address of its request; discard count nonzero SHALL drop the response and decrement discard count.
REQ-020 Response-to-head latency SHALL be 1 cycle when queue is empty (head_valid rises the cycle after mem_resp_valid).
REQ-021 deq with head_valid=1 SHALL pop the head; deq with head_valid=0 SHALL be ignored.
REQ-022 Simultaneous deq and enqueue on a full queue SHALL be legal (occupancy unchanged); enqueue onto a full queue cannot occur by REQ-017.
REQ-023 redirect SHALL: empty queue next cycle, set fetch pointer to redirect_pc, set discard count = in-flight count after this cycle's accept/response.
REQ-024 redirect SHALL take priority over deq and enqueue in the same cycle; a response arriving in the redirect cycle is dropped; a request accepted in the redirect cycle is counted for discard.
REQ-025 head_valid SHALL be 0 in the cycle after redirect; mem_req_addr SHALL equal redirect_pc in that cycle.
REQ-026 mem_resp_valid with zero in-flight SHALL be ignored (protocol violation, no state change).
REQ-027 Queue pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 While rst=1: queue empty, head_valid=0, in-flight=0, discard=0, fetch pointer=RESET_PC, mem_req_valid=0.
REQ-029 head_instr/head_pc SHALL read 32'h0000_0013 / RESET_PC while head_valid=0 after reset.
REQ-030 First cycle after rst falls: mem_req_valid=1, mem_req_addr=RESET_PC.
REQ-031 rst asserted mid-operation SHALL abandon in-flight requests; their later responses are not enqueued (in-flight=0, so ignored by REQ-026).

Configuration
REQ-032 Macro PREFETCH_BYPASS_EN defined: when queue empty and a non-discarded response arrives, head_valid/head_instr/head_pc SHALL reflect it combinationally the same cycle; deq that cycle consumes it without enqueuing.
REQ-033 Macro PREFETCH_BYPASS_EN undefined: no combinational path from mem_resp_* to head_*; REQ-020 latency applies.

Verification
REQ-034 Reset release, ready=1, 2-cycle memory latency -> requests 0x0,0x4,0x8,0xC, then mem_req_valid=0 until deq; head_pc=0x0 first.
REQ-035 Queue full (4), hold deq=0 -> mem_req_valid=0; one deq -> exactly one new request at next sequential address.
REQ-036 Two in flight at 0x10,0x14, redirect to 0x100 -> both responses dropped; head_pc=0x100 with its instruction.
REQ-037 redirect, deq and mem_resp_valid same cycle -> queue empty next cycle, response dropped, mem_req_addr=redirect_pc.
REQ-038 rst pulse with 3 requests in flight -> stale responses ignored; first request after release at RESET_PC.
REQ-039 Empty queue, response 0xDEADBEEF -> head_valid same cycle with PREFETCH_BYPASS_EN, next cycle without.

Source files
------------

// File: rtl/cpu_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// cpu_prefetch_buffer
//   Instruction prefetch queue between an in-order instruction memory and the
//   fetch stage. Keeps up to DEPTH requests outstanding (queued + in flight),
//   tags every returned word with its fetch address and flushes on redirect.
//
// Parameters
//   DEPTH     queue entries, power of two, 2..16
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk              clock, all state on rising edge
//   rst              asynchronous active-high reset
//   redirect         flush queue and in-flight work, refetch from redirect_pc
//   redirect_pc      new fetch address (sampled with redirect)
//   deq              fetch stage consumes the head entry
//   head_valid       head entry present
//   head_instr       head instruction word (NOP 0x13 when empty)
//   head_pc          head instruction address (RESET_PC when empty)
//   mem_req_valid    read request offered
//   mem_req_addr     address of the offered request
//   mem_req_ready    memory accepts the request this cycle
//   mem_resp_valid   read data returned, in request order
//   mem_resp_data    returned instruction word
//
// Build option
//   PREFETCH_BYPASS_EN  when defined, a response arriving at an empty queue
//                       is forwarded to head_* in the same cycle.
// ---------------------------------------------------------------------------
module cpu_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        deq,
    output logic        head_valid,
    output logic [31:0] head_instr,
    output logic [31:0] head_pc,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;     // address of the next response that will be kept
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;    // includes responses still to be discarded
    logic [CW-1:0] r_discard;
    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc    [DEPTH];

    logic          w_req_valid;
    logic          w_accept;
    logic          w_resp;
    logic          w_resp_keep;
    logic          w_q_valid;
    logic          w_pop;
    logic          w_enq;
    logic          w_bypass_take;
    logic [CW-1:0] w_inflight_nxt;

    // Occupancy counts queued entries plus every outstanding request, so a
    // response can always find a free slot.
    assign w_req_valid = !rst && (({1'b0, r_count} + {1'b0, r_inflight}) < DEPTH_C);
    assign w_accept    = w_req_valid && mem_req_ready;

    // A response with nothing outstanding is a protocol violation; ignore it.
    assign w_resp      = mem_resp_valid && (r_inflight != '0);
    assign w_resp_keep = w_resp && (r_discard == '0) && !redirect;

    assign w_q_valid   = (r_count != '0);
    assign w_pop       = deq && w_q_valid && !redirect;
    assign w_enq       = w_resp_keep && !w_bypass_take;

    assign w_inflight_nxt = r_inflight + CW'(w_accept) - CW'(w_resp);

    assign mem_req_valid = w_req_valid;
    assign mem_req_addr  = r_fetch_pc;

`ifdef PREFETCH_BYPASS_EN
    // An empty queue lets a kept response appear at the head immediately;
    // consuming it in the same cycle means it never occupies a slot.
    assign w_bypass_take = !w_q_valid && w_resp_keep && deq;

    always_comb begin
        head_valid = 1'b0;
        head_instr = NOP;
        head_pc    = RESET_PC;
        if (w_q_valid) begin
            head_valid = 1'b1;
            head_instr = r_instr[r_rd_ptr];
            head_pc    = r_pc[r_rd_ptr];
        end else if (w_resp_keep) begin
            head_valid = 1'b1;
            head_instr = mem_resp_data;
            head_pc    = r_resp_pc;
        end
    end
`else
    assign w_bypass_take = 1'b0;

    always_comb begin
        head_valid = 1'b0;
        head_instr = NOP;
        head_pc    = RESET_PC;
        if (w_q_valid) begin
            head_valid = 1'b1;
            head_instr = r_instr[r_rd_ptr];
            head_pc    = r_pc[r_rd_ptr];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (redirect) begin
                // Everything still outstanding after this cycle belongs to the
                // old stream, including a request accepted right now.
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_discard  <= w_inflight_nxt;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_resp && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_resp_keep) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_enq) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_enq) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_instr[r_wr_ptr] <= mem_resp_data;
            r_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end

endmodule
